// File: rtl/bram_fifo_pkg.sv
// Shared constants for the BRAM-backed first-word-fall-through FIFO.
package bram_fifo_pkg;

    localparam int DEF_ADDR_SZ = 8;
    localparam int DEF_DATA_SZ = 16;
    localparam int DEPTH       = 2 ** DEF_ADDR_SZ;
    localparam int PTR_SZ      = DEF_ADDR_SZ + 1;

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer: W-bit wrapping counter with async active-low reset and increment enable.
module fifo_ptr
    import bram_fifo_pkg::*;
#(
    parameter int W = PTR_SZ
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (i_inc) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO controller driving an external 256x16 dual-port BRAM.
// Optional high-water mark on o_hwm is enabled by defining BRAM_FIFO_HWM_EN.
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int ADDR_SZ = DEF_ADDR_SZ,
    parameter int DATA_SZ = DEF_DATA_SZ
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_SZ-1:0] i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_SZ-1:0] o_data,
    output logic [ADDR_SZ:0]   o_level,
    output logic [ADDR_SZ:0]   o_hwm,
    output logic               o_bram_wr_en,
    output logic [ADDR_SZ-1:0] o_bram_waddr,
    output logic [DATA_SZ-1:0] o_bram_wdata,
    output logic               o_bram_rd_en,
    output logic [ADDR_SZ-1:0] o_bram_raddr,
    input  logic [DATA_SZ-1:0] i_bram_rdata
);

    localparam int PTR_W = ADDR_SZ + 1;
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(2 ** ADDR_SZ);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] stored;
    logic             push;
    logic             pop_issue;

    fifo_ptr #(.W(PTR_W)) u_wptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (push),
        .o_cnt   (wptr)
    );

    fifo_ptr #(.W(PTR_W)) u_rptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (pop_issue),
        .o_cnt   (rptr)
    );

    assign stored  = wptr - rptr;
    assign o_ready = (stored != FULL_CNT);

    // Gating with i_rst_n keeps the BRAM from being written while reset is held.
    assign push      = i_valid & o_ready & i_rst_n;
    assign pop_issue = (stored != '0) & (!o_valid | i_ready);

    assign o_bram_wr_en = push;
    assign o_bram_waddr = wptr[ADDR_SZ-1:0];
    assign o_bram_wdata = i_data;
    assign o_bram_rd_en = pop_issue;
    assign o_bram_raddr = rptr[ADDR_SZ-1:0];

    // BRAM read data is registered and held while rd_en is low, so it is the head word.
    assign o_data = i_bram_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= pop_issue | (o_valid & !i_ready);
        end
    end

    assign o_level = stored + PTR_W'(o_valid);

`ifdef BRAM_FIFO_HWM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hwm <= '0;
        end else if (o_level > o_hwm) begin
            o_hwm <= o_level;
        end
    end
`else
    assign o_hwm = '0;
`endif

endmodule

// File: tb/tb_bram_fifo.sv
// Self-checking bench for bram_fifo with a behavioural 256x16 registered-read BRAM beside it.
module tb_bram_fifo;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [AW:0]   o_level;
    logic [AW:0]   o_hwm;
    logic          bram_wr_en;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_wdata;
    logic          bram_rd_en;
    logic [AW-1:0] bram_raddr;
    logic [DW-1:0] bram_rdata;

    logic [DW-1:0] mem [2**AW];

    int            checks = 0;
    int            errors = 0;
    int            accepted = 0;
    int            popped = 0;
    logic [DW-1:0] last_pop;
    logic [DW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bram_fifo u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_level      (o_level),
        .o_hwm        (o_hwm),
        .o_bram_wr_en (bram_wr_en),
        .o_bram_waddr (bram_waddr),
        .o_bram_wdata (bram_wdata),
        .o_bram_rd_en (bram_rd_en),
        .o_bram_raddr (bram_raddr),
        .i_bram_rdata (bram_rdata)
    );

    // Dual-port BRAM: synchronous write, registered read that holds when rd_en is low.
    always @(posedge clk) begin
        if (bram_wr_en) mem[bram_waddr] <= bram_wdata;
        if (bram_rd_en) bram_rdata <= mem[bram_raddr];
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected-data recorder: every accepted upstream word is queued.
    always @(negedge clk) begin
        if (rst_n && i_valid && o_ready) begin
            exp_q.push_back(i_data);
            accepted++;
        end
    end

    // Monitor: every downstream handshake pops and compares.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no word at %0t", o_data, $time);
            end else begin
                check("pop_data", {16'b0, o_data}, {16'b0, exp_q.pop_front()});
            end
            popped++;
            last_pop = o_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((o_valid || exp_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        check("drain_done", {31'b0, (o_valid || exp_q.size() != 0)}, 32'd0);
    endtask

    task automatic fill_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_data  = base + DW'(i);
            tick();
        end
        i_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc0;
        int pop0;
        int bubbles;
        int hwm_exp;

        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_data  = 16'hdead;
        i_ready = 1'b0;

        // Reset held with i_valid high: nothing written, FIFO idle.
        repeat (2) begin
            @(negedge clk);
            check("reset_valid", {31'b0, o_valid}, 32'd0);
            check("reset_ready", {31'b0, o_ready}, 32'd1);
            check("reset_level", {23'b0, o_level}, 32'd0);
            check("reset_wr_en", {31'b0, bram_wr_en}, 32'd0);
            check("reset_hwm", {23'b0, o_hwm}, 32'd0);
        end
        tick();
        i_valid = 1'b0;
        rst_n   = 1'b1;
        tick();

        // Single word 0x1234 with i_ready low.
        i_valid = 1'b1;
        i_data  = 16'h1234;
        @(negedge clk);
        check("single_wr_en", {31'b0, bram_wr_en}, 32'd1);
        check("single_waddr", {24'b0, bram_waddr}, 32'd0);
        check("single_wdata", {16'b0, bram_wdata}, 32'h1234);
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        check("single_valid_early", {31'b0, o_valid}, 32'd0);
        check("single_level_bram", {23'b0, o_level}, 32'd1);
        tick();
        repeat (5) begin
            @(negedge clk);
            check("single_valid", {31'b0, o_valid}, 32'd1);
            check("single_data_hold", {16'b0, o_data}, 32'h1234);
            check("single_level", {23'b0, o_level}, 32'd1);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        @(negedge clk);
        check("single_empty_valid", {31'b0, o_valid}, 32'd0);
        check("single_empty_level", {23'b0, o_level}, 32'd0);
        tick();

        // Offer 258 words with i_ready low: 257 fit (256 in BRAM plus head).
        acc0 = accepted;
        pop0 = popped;
        fill_words(258, 16'h0000);
        check("fill_accepted", accepted - acc0, 32'd257);
        @(negedge clk);
        check("full_ready", {31'b0, o_ready}, 32'd0);
        check("full_level", {23'b0, o_level}, 32'd257);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(negedge clk);
        check("full_ready_no_comb", {31'b0, o_ready}, 32'd0);
        tick();
        @(negedge clk);
        check("full_ready_rise", {31'b0, o_ready}, 32'd1);
        wait_drain(400);
        check("fill_popped", popped - pop0, 32'd257);
        check("fill_last_word", {16'b0, last_pop}, 32'h0100);
        i_ready = 1'b0;
        tick();

        // Streaming: both sides ready, one word per cycle after the fill latency.
        acc0    = accepted;
        pop0    = popped;
        bubbles = 0;
        i_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            i_valid = 1'b1;
            i_data  = 16'h1000 + DW'(i);
            @(negedge clk);
            if (i >= 2 && !o_valid) bubbles++;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        check("stream_accepted", accepted - acc0, 32'd1000);
        check("stream_bubbles", bubbles, 32'd0);
        wait_drain(20);
        check("stream_popped", popped - pop0, 32'd1000);
        i_ready = 1'b0;
        tick();

        // Random traffic with an asynchronous reset pulse in the middle.
        for (int c = 0; c < 300; c++) begin
            if (c == 150) begin
                rst_n = 1'b0;
                #1;
                check("mid_reset_valid", {31'b0, o_valid}, 32'd0);
                check("mid_reset_level", {23'b0, o_level}, 32'd0);
                check("mid_reset_ready", {31'b0, o_ready}, 32'd1);
                check("mid_reset_rd_en", {31'b0, bram_rd_en}, 32'd0);
                check("mid_reset_wr_en", {31'b0, bram_wr_en}, 32'd0);
                exp_q.delete();
                tick();
                tick();
                rst_n = 1'b1;
            end else begin
                i_valid = 1'($urandom_range(0, 1));
                i_ready = 1'($urandom_range(0, 1));
                i_data  = DW'($urandom_range(0, 65535));
                tick();
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_drain(400);
        i_ready = 1'b0;

        // High-water mark: fresh reset, fill to 100, drain.
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
`ifdef BRAM_FIFO_HWM_EN
        hwm_exp = 100;
`else
        hwm_exp = 0;
`endif
        fill_words(100, 16'h2000);
        tick();
        tick();
        check("hwm_fill_level", {23'b0, o_level}, 32'd100);
        check("hwm_at_peak", {23'b0, o_hwm}, hwm_exp);
        i_ready = 1'b1;
        wait_drain(200);
        i_ready = 1'b0;
        tick();
        check("hwm_drained_level", {23'b0, o_level}, 32'd0);
        check("hwm_held", {23'b0, o_hwm}, hwm_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
